// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch prefetch queue: queue entry layout,
// control states and the NOP returned when the queue has nothing to offer.
package fetch_pkg;
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } pfq_state_e;
endpackage

// File: rtl/pfq_fifo.sv
// Circular buffer of fetch entries with push/pop/clear and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module pfq_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NBITS = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  fetch_entry_t           data_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  output fetch_entry_t           head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [NBITS-1:0] pc_mem    [DEPTH];
  logic [NBITS-1:0] instr_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) begin
      pc_mem[wr_ptr_q]    <= data_i.pc;
      instr_mem[wr_ptr_q] <= data_i.instr;
    end
  end

  assign head_o  = '{pc: pc_mem[rd_ptr_q], instr: instr_mem[rd_ptr_q]};
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: issues up to MAX_OUT requests, buffers DEPTH
// responses, flushes on redirect. Define PFQ_BYPASS_EN for same-cycle bypass.
//
//   state | meaning
//   RUN   | no stale responses pending; valid responses are enqueued
//   DRAIN | drop_q > 0; valid responses are stale and discarded
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned      NBITS    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter int unsigned      MAX_OUT  = 2,
  parameter logic [NBITS-1:0] RESET_PC = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   fetch_en_i,
  input  logic                   redirect_i,
  input  logic [NBITS-1:0]       redirect_pc_i,
  output logic                   proc_req_o,
  output logic [NBITS-1:0]       pc2mem_o,
  input  logic                   mem_rdy_i,
  input  logic                   valid_i,
  input  logic [NBITS-1:0]       rdata_i,
  input  logic                   deq_ready_i,
  output logic                   out_valid_o,
  output logic [NBITS-1:0]       ir_o,
  output logic [NBITS-1:0]       pc_o,
  output logic [NBITS-1:0]       npc_o,
  output logic                   stall_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned CW     = $clog2(DEPTH) + 1;
  localparam int unsigned AW     = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned DROP_W = 8;
  localparam logic [CW-1:0] MAX_OUT_V = CW'(MAX_OUT);
  localparam logic [CW:0]   DEPTH_V   = (CW + 1)'(DEPTH);

  pfq_state_e        state_q, state_d;
  logic [NBITS-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [NBITS-1:0]  infl_addr_q [MAX_OUT];
  logic [AW-1:0]     infl_wr_q, infl_wr_d, infl_rd_q, infl_rd_d;

  logic              accept, resp_live, resp_stale, bypass;
  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occupancy;
  fetch_entry_t      live_entry, head_entry;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(MAX_OUT - 1)) ? '0 : p + AW'(1);
  endfunction

  // Queued entries plus outstanding requests must never exceed DEPTH.
  assign occupancy  = {1'b0, fifo_count} + {1'b0, outst_q};
  assign proc_req_o = fetch_en_i & ~redirect_i & (outst_q < MAX_OUT_V) & (occupancy < DEPTH_V);
  assign pc2mem_o   = fetch_pc_q;
  assign accept     = proc_req_o & mem_rdy_i;
  assign resp_live  = valid_i & (state_q == RUN) & ~redirect_i;
  assign resp_stale = valid_i & (state_q == DRAIN) & ~redirect_i;

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    outst_d    = outst_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      drop_d     = drop_q + DROP_W'(outst_q) - DROP_W'(valid_i);
      outst_d    = '0;
      fetch_pc_d = redirect_pc_i;
    end else begin
      if (accept)     fetch_pc_d = fetch_pc_q + NBITS'(4);
      if (resp_stale) drop_d     = drop_q - DROP_W'(1);
      outst_d = outst_q + CW'(accept) - CW'(resp_live);
    end
    unique case (state_q)
      RUN:     if (drop_d != '0) state_d = DRAIN;
      DRAIN:   if (drop_d == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    infl_wr_d = infl_wr_q;
    infl_rd_d = infl_rd_q;
    if (redirect_i) begin
      infl_wr_d = '0;
      infl_rd_d = '0;
    end else begin
      if (accept)    infl_wr_d = ptr_inc(infl_wr_q);
      if (resp_live) infl_rd_d = ptr_inc(infl_rd_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      infl_wr_q  <= '0;
      infl_rd_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      infl_wr_q  <= infl_wr_d;
      infl_rd_q  <= infl_rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) infl_addr_q[infl_wr_q] <= fetch_pc_q;
  end

  assign live_entry = '{pc: infl_addr_q[infl_rd_q], instr: rdata_i};

`ifdef PFQ_BYPASS_EN
  assign bypass = fifo_empty & resp_live;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = resp_live & ~(bypass & deq_ready_i);
  assign fifo_pop  = ~fifo_empty & deq_ready_i & ~redirect_i;

  pfq_fifo #(.DEPTH(DEPTH), .NBITS(NBITS)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (live_entry),
    .pop_i   (fifo_pop),
    .clear_i (redirect_i),
    .head_o  (head_entry),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  always_comb begin
    out_valid_o = 1'b0;
    ir_o        = NOP_INSTR;
    pc_o        = '0;
    npc_o       = '0;
    if (bypass) begin
      out_valid_o = 1'b1;
      ir_o        = live_entry.instr;
      pc_o        = live_entry.pc;
      npc_o       = live_entry.pc + NBITS'(4);
    end else if (!fifo_empty && !redirect_i) begin
      out_valid_o = 1'b1;
      ir_o        = head_entry.instr;
      pc_o        = head_entry.pc;
      npc_o       = head_entry.pc + NBITS'(4);
    end
  end

  assign stall_o = ~out_valid_o;
  assign count_o = fifo_count;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(resp_live && fifo_full));
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed vector table, corner sequences and
// randomized traffic against a queue-level reference model with a memory model.
module tb_fetch_prefetch_queue;
  localparam int DEPTH = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        fe, rd, mr, valid, dq;
  logic [31:0] rdpc, rdata;
  logic        proc_req, out_valid, stall;
  logic [31:0] pc2mem, ir, pc, npc;
  logic [2:0]  count;

  fetch_prefetch_queue dut (
    .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fe), .redirect_i(rd), .redirect_pc_i(rdpc),
    .proc_req_o(proc_req), .pc2mem_o(pc2mem), .mem_rdy_i(mr), .valid_i(valid), .rdata_i(rdata),
    .deq_ready_i(dq), .out_valid_o(out_valid), .ir_o(ir), .pc_o(pc), .npc_o(npc),
    .stall_o(stall), .count_o(count)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  // memory model: in-order responses, one per cycle, latency lat_min..lat_max
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int lat_min = 1, lat_max = 1, vprob = 100, last_due = 0;

  // reference model: queue contents, in-flight live addresses, stale count
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_infl[$];
  int          m_drop;
  logic [31:0] m_fpc, m_next;

  logic        s_req, s_ov, s_stall;
  logic [31:0] s_pc2mem, s_ir, s_pc, s_npc, s_cnt;

  task automatic cycle(input logic i_fe, input logic i_rd, input logic [31:0] i_rdpc,
                       input logic i_mr, input logic i_dq);
    bit exp_req, exp_ov, byp;
    int occ, d;
    ent_t h;
    fe = i_fe; rd = i_rd; rdpc = i_rdpc; mr = i_mr; dq = i_dq;
    valid = 1'b0; rdata = '0;
    if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < vprob) begin
      valid = 1'b1;
      rdata = mem_word(mq[0].addr);
    end
    #4;
    s_req = proc_req; s_pc2mem = pc2mem; s_ov = out_valid; s_stall = stall;
    s_ir = ir; s_pc = pc; s_npc = npc; s_cnt = 32'(count);

    occ = m_q.size();
    exp_req = i_fe && !i_rd && (m_infl.size() < MAX_OUT) && (occ + m_infl.size() < DEPTH);
    byp = 1'b0;
`ifdef PFQ_BYPASS_EN
    byp = valid && occ == 0 && m_drop == 0 && !i_rd && m_infl.size() > 0;
`endif
    exp_ov = !i_rd && (occ > 0 || byp);
    h = '{32'h0, 32'h0};
    if (byp) h = '{m_infl[0], rdata};
    else if (occ > 0) h = m_q[0];

    chk("proc_req", 32'(s_req), 32'(exp_req));
    chk("pc2mem", s_pc2mem, m_fpc);
    chk("out_valid", 32'(s_ov), 32'(exp_ov));
    chk("stall", 32'(s_stall), 32'(!exp_ov));
    chk("count", s_cnt, 32'(occ));
    chk("ir", s_ir, exp_ov ? h.instr : NOP);
    chk("pc", s_pc, exp_ov ? h.pc : 32'h0);
    chk("npc", s_npc, exp_ov ? h.pc + 32'd4 : 32'h0);

    if (valid) void'(mq.pop_front());
    if (s_req && i_mr) begin
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{s_pc2mem, d});
    end

    if (i_rd) begin
      m_q.delete();
      m_drop += m_infl.size() - (valid ? 1 : 0);
      m_infl.delete();
      m_fpc = i_rdpc;
      m_next = i_rdpc;
    end else begin
      if (exp_ov && i_dq) begin
        chk("deq_seq_pc", s_pc, m_next);
        chk("deq_ir_mem", s_ir, mem_word(s_pc));
        m_next += 32'd4;
        if (!byp) void'(m_q.pop_front());
      end
      if (valid) begin
        if (m_drop > 0) m_drop--;
        else if (m_infl.size() > 0) begin
          ent_t e;
          e.pc = m_infl.pop_front();
          e.instr = rdata;
          if (!(byp && i_dq)) m_q.push_back(e);
        end
      end
      if (s_req && i_mr) begin
        m_infl.push_back(m_fpc);
        m_fpc += 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    fe = 0; rd = 0; rdpc = '0; mr = 0; dq = 0; valid = 0; rdata = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_proc_req", 32'(proc_req), 32'h0);
    chk("rst_pc2mem", pc2mem, RESET_PC);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_stall", 32'(stall), 32'h1);
    chk("rst_ir", ir, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_npc", npc, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    mq.delete(); m_q.delete(); m_infl.delete();
    m_drop = 0; m_fpc = RESET_PC; m_next = RESET_PC;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  typedef struct {
    bit fe; bit rd; bit dq; logic [31:0] rdpc;
    bit e_req; logic [31:0] e_pc2mem; bit e_ov; logic [31:0] e_pc; int e_cnt;
  } vec_t;

  function automatic vec_t v(bit f, bit r, bit q, logic [31:0] rp,
                             bit req, logic [31:0] p2m, bit ov, logic [31:0] hp, int cnt);
    vec_t x;
    x.fe = f; x.rd = r; x.dq = q; x.rdpc = rp;
    x.e_req = req; x.e_pc2mem = p2m; x.e_ov = ov; x.e_pc = hp; x.e_cnt = cnt;
    return x;
  endfunction

  initial begin
    vec_t tbl[17];
    logic prev_req, prev_mr;
    logic [31:0] prev_p2m;
    bit seen;

    tbl[0]  = v(1,0,1,0,     1,32'h00, 0,32'h00,0);
    tbl[1]  = v(1,0,1,0,     1,32'h04, 0,32'h00,0);
    tbl[2]  = v(1,0,1,0,     1,32'h08, 1,32'h00,1);
    tbl[3]  = v(1,0,1,0,     1,32'h0c, 1,32'h04,1);
    tbl[4]  = v(1,0,1,0,     1,32'h10, 1,32'h08,1);
    tbl[5]  = v(1,0,0,0,     1,32'h14, 1,32'h0c,1);
    tbl[6]  = v(1,0,0,0,     1,32'h18, 1,32'h0c,2);
    tbl[7]  = v(1,0,0,0,     0,32'h1c, 1,32'h0c,3);
    tbl[8]  = v(1,0,0,0,     0,32'h1c, 1,32'h0c,4);
    tbl[9]  = v(1,0,1,0,     0,32'h1c, 1,32'h0c,4);
    tbl[10] = v(1,0,1,0,     1,32'h1c, 1,32'h10,3);
    tbl[11] = v(1,0,1,0,     1,32'h20, 1,32'h14,2);
    tbl[12] = v(1,0,1,0,     1,32'h24, 1,32'h18,2);
    tbl[13] = v(1,1,1,32'h100, 0,32'h28, 0,32'h00,2);
    tbl[14] = v(1,0,1,0,     1,32'h100,0,32'h00,0);
    tbl[15] = v(1,0,1,0,     1,32'h104,0,32'h00,0);
    tbl[16] = v(1,0,1,0,     1,32'h108,1,32'h100,1);

    do_reset();
`ifndef PFQ_BYPASS_EN
    lat_min = 1; lat_max = 1; vprob = 100;
    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].fe, tbl[i].rd, tbl[i].rdpc, 1'b1, tbl[i].dq);
      chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].e_req));
      chk($sformatf("tbl%0d_pc2mem", i), s_pc2mem, tbl[i].e_pc2mem);
      chk($sformatf("tbl%0d_ov", i), 32'(s_ov), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_cnt", i), s_cnt, 32'(tbl[i].e_cnt));
    end
`else
    lat_min = 1; lat_max = 1; vprob = 100;
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 1);
    chk("byp_ov", 32'(s_ov), 32'h1);
    chk("byp_pc", s_pc, 32'h0);
    cycle(1, 0, 0, 1, 1);
    chk("byp_cnt", s_cnt, 32'h0);
`endif

    // latency 3, two outstanding, redirect drains both stale responses
    do_reset();
    lat_min = 3; lat_max = 3; vprob = 100;
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 1, 32'h100, 1, 1);
    chk("redir_req_blocked", 32'(s_req), 32'h0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1, 0, 0, 1, 1);
      if (s_ov) begin
        seen = 1;
        chk("redir_first_pc", s_pc, 32'h100);
        chk("redir_first_npc", s_npc, 32'h104);
      end
    end
    if (!seen) chk("redir_timeout", 32'h0, 32'h1);

    // mem_rdy toggling, fetch_en low for 3 cycles
    do_reset();
    lat_min = 2; lat_max = 2;
    prev_req = 0; prev_mr = 0; prev_p2m = '0;
    for (int i = 0; i < 24; i++) begin
      cycle(!(i >= 6 && i < 9), 1'b0, 32'h0, 1'(i % 2), 1'b1);
      if (prev_req && !prev_mr) chk("addr_stable", s_pc2mem, prev_p2m);
      prev_req = s_req; prev_mr = 1'(i % 2); prev_p2m = s_pc2mem;
    end

    // randomized traffic with one mid-stream reset
    do_reset();
    lat_min = 1; lat_max = 4; vprob = 70;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cycle($urandom_range(9) != 0, $urandom_range(39) == 0, $urandom() & 32'hFFFF_FFFC,
            1'($urandom_range(1)), $urandom_range(3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
